seven_seg_decoder: RTL

SEVEN_SEG_DECODER -- requirements
Module: seven_seg_decoder

---
 rtl/seven_seg_pkg.sv | 44 ++++
 rtl/seg_pattern_decode.sv | 40 ++++
 rtl/seven_seg_decoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared segment patterns, FSM encoding and anode helpers for the
// seven-segment scan decoder.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } segState_t;

  // Active-low cathode patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic oneLow(input logic [7:0] an);
    logic [7:0] lo;
    lo = ~an;
    return (lo != 8'd0) && ((lo & (lo - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [2:0] lowIndex(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (!an[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Cathode pattern to BCD nibble; hex letters decode only when
// SEVEN_SEG_DECODER_HEX_EN is defined.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
`ifdef SEVEN_SEG_DECODER_HEX_EN
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
`endif
      SEG_BLANK: blank  = 1'b1;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_decoder.sv
// Recovers an 8-digit value from a multiplexed 7-segment scan.
// Hex digits are accepted when SEVEN_SEG_DECODER_HEX_EN is defined.
module seven_seg_decoder
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  anode,
  input  logic [6:0]  cathode,
  input  logic        dp,
  output logic [31:0] data,
  output logic [7:0]  dp_mask,
  output logic [7:0]  blank_mask,
  output logic [7:0]  err_mask,
  output logic        frame_valid,
  output logic        stale
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]      sAnode, pAnode;
  logic [6:0]      sCath, pCath;
  logic            sDp, pDp;
  segState_t       state, stateNext;
  logic [SW-1:0]   stCnt, stCntNext;
  logic [TW-1:0]   toCnt;
  logic [7:0]      collected, collectedNext;
  logic [7:0][3:0] shData;
  logic [7:0]      shDp, shBlank, shErr;

  logic       sampleValid, changed, capture, toHit, full;
  logic [2:0] idx;
  logic [3:0] decNib;
  logic       decBlank, decErr;

  seg_pattern_decode uDecode (
    .seg    (sCath),
    .nibble (decNib),
    .blank  (decBlank),
    .err    (decErr)
  );

  assign sampleValid = oneLow(sAnode);
  assign changed = {sAnode, sCath, sDp} != {pAnode, pCath, pDp};
  assign idx = lowIndex(sAnode);
  assign full = collected == 8'hFF;

  always_comb begin
    stateNext = state;
    stCntNext = stCnt;
    capture   = 1'b0;
    if (!sampleValid) begin
      stateNext = WAIT;
      stCntNext = '0;
    end else if (state == WAIT || changed) begin
      stateNext = SETTLE;
      stCntNext = SW'(1);
    end else if (state == SETTLE) begin
      stCntNext = stCnt + SW'(1);
    end
    if (stateNext == SETTLE && stCntNext == SW'(STABLE_CYCLES)) begin
      capture   = 1'b1;
      stateNext = HELD;
    end
  end

  // A capture in the same cycle as the timeout wins
  assign toHit = !capture && (toCnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    collectedNext = (full || toHit) ? 8'h00 : collected;
    if (capture) collectedNext[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sAnode      <= 8'hFF;
      pAnode      <= 8'hFF;
      sCath       <= SEG_BLANK;
      pCath       <= SEG_BLANK;
      sDp         <= 1'b1;
      pDp         <= 1'b1;
      state       <= WAIT;
      stCnt       <= '0;
      toCnt       <= '0;
      collected   <= 8'h00;
      shData      <= '0;
      shDp        <= 8'h00;
      shBlank     <= 8'h00;
      shErr       <= 8'h00;
      data        <= 32'h0;
      dp_mask     <= 8'h00;
      blank_mask  <= 8'h00;
      err_mask    <= 8'h00;
      frame_valid <= 1'b0;
      stale       <= 1'b1;
    end else begin
      sAnode      <= anode;
      sCath       <= cathode;
      sDp         <= dp;
      pAnode      <= sAnode;
      pCath       <= sCath;
      pDp         <= sDp;
      state       <= stateNext;
      stCnt       <= stCntNext;
      collected   <= collectedNext;
      frame_valid <= 1'b0;
      if (capture)
        toCnt <= '0;
      else if (toCnt != TW'(TIMEOUT_CYCLES))
        toCnt <= toCnt + TW'(1);
      if (capture) begin
        shData[idx]  <= decNib;
        shDp[idx]    <= ~sDp;
        shBlank[idx] <= decBlank;
        shErr[idx]   <= decErr;
      end
      if (full) begin
        data        <= shData;
        dp_mask     <= shDp;
        blank_mask  <= shBlank;
        err_mask    <= shErr;
        frame_valid <= 1'b1;
        stale       <= 1'b0;
      end else if (toHit) begin
        stale <= 1'b1;
      end
    end
  end

endmodule
